// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: per-channel LED pattern generator (OFF, ON, SPARK, SPARK1,
// BLING, BREATH) feeding a serial shift-register frame (74HC595 style).
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   vld                   - one-cycle strobe sampling reg_din
//   reg_din[4*NUM_LED]    - 4-bit mode code per channel
//   reg_breath[8]         - BREATH ramp length (all channels)
//   led_bling[NUM_LED]    - per-channel BLING advance tick
//   sft_shcp/sft_ds       - shift clock / serial data (led[0] first)
//   sft_stcp              - storage latch pulse after the last bit
//   busy                  - high for the whole frame including the latch cycle
module led_pwm_ctrl #(
  parameter int unsigned NUM_LED    = 8,
  parameter int unsigned CNT_W      = 25,
  parameter int unsigned SPARK_MAX  = 30000000,
  parameter int unsigned BLING_MAX  = 8,
  parameter int unsigned BREATH_MAX = 24'h180000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vld,
  input  logic [4*NUM_LED-1:0]   reg_din,
  input  logic [7:0]             reg_breath,
  input  logic [NUM_LED-1:0]     led_bling,
  output logic                   sft_shcp,
  output logic                   sft_ds,
  output logic                   sft_stcp,
  output logic                   busy
);

  localparam int unsigned IDX_W = $clog2(NUM_LED) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LED - 1);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_SPARK  = CNT_W'(SPARK_MAX);
  localparam logic [CNT_W-1:0] C_BLING  = CNT_W'(BLING_MAX);
  localparam logic [CNT_W-1:0] C_BREATH = CNT_W'(BREATH_MAX);

  localparam logic [3:0] M_OFF    = 4'd0;
  localparam logic [3:0] M_ON     = 4'd1;
  localparam logic [3:0] M_SPARK  = 4'd2;
  localparam logic [3:0] M_SPARK1 = 4'd3;
  localparam logic [3:0] M_BLING  = 4'd4;
  localparam logic [3:0] M_BREATH = 4'd5;

  typedef enum logic [1:0] {IDLE, DATA_LO, DATA_HI, LATCH} state_t;

  // Channel state
  logic [NUM_LED-1:0]   r_led, w_led_nxt;
  logic [CNT_W-1:0]     r_tmr [NUM_LED];
  logic [CNT_W-1:0]     w_tmr_nxt [NUM_LED];
  logic [7:0]           r_d [NUM_LED];
  logic [7:0]           w_d_nxt [NUM_LED];
  logic [7:0]           r_r [NUM_LED];
  logic [7:0]           w_r_nxt [NUM_LED];
  logic [NUM_LED-1:0]   r_f, w_f_nxt;
  logic [4*NUM_LED-1:0] r_din_prev;
  logic [3:0]           w_code [NUM_LED];
  logic [3:0]           w_mode [NUM_LED];
  logic [NUM_LED-1:0]   w_keep;
  logic                 r_req;

  // Shifter state
  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [NUM_LED-1:0]   r_frame, w_shifted;
  logic                 r_pend, w_load;

  always_comb begin
    for (int unsigned i = 0; i < NUM_LED; i++) begin
      w_led_nxt[i] = r_led[i];
      w_tmr_nxt[i] = r_tmr[i];
      w_d_nxt[i]   = r_d[i];
      w_r_nxt[i]   = r_r[i];
      w_f_nxt[i]   = r_f[i];
      w_code[i]    = reg_din[4*i +: 4];
      w_mode[i]    = r_din_prev[4*i +: 4];
      // A strobe repeating the running SPARK1/BLING/BREATH code is ignored,
      // so the channel keeps running in its current phase.
      w_keep[i]    = (w_code[i] >= M_SPARK1) && (w_code[i] <= M_BREATH) &&
                     (w_code[i] == w_mode[i]);
      if (vld && !w_keep[i]) begin
        case (w_code[i])
          M_OFF, M_ON: begin
            w_led_nxt[i] = w_code[i][0];
            w_tmr_nxt[i] = '0;
            w_d_nxt[i]   = '0;
            w_r_nxt[i]   = '0;
            w_f_nxt[i]   = 1'b0;
          end
          M_SPARK, M_SPARK1, M_BLING: begin
            w_led_nxt[i] = 1'b1;
            w_tmr_nxt[i] = C_ONE;
          end
          M_BREATH: begin
            w_tmr_nxt[i] = C_ONE;
            w_led_nxt[i] = r_f[i] ? (r_d[i] < r_r[i]) : (r_d[i] >= r_r[i]);
          end
          default: ;
        endcase
      end else begin
        case (w_mode[i])
          M_SPARK: begin
            if (r_tmr[i] != '0) begin
              if (r_tmr[i] >= C_SPARK) begin
                w_led_nxt[i] = ~r_led[i];
                w_tmr_nxt[i] = '0;
              end else begin
                w_tmr_nxt[i] = r_tmr[i] + C_ONE;
              end
            end
          end
          M_SPARK1: begin
            if (r_tmr[i] >= C_SPARK) begin
              w_led_nxt[i] = ~r_led[i];
              w_tmr_nxt[i] = C_ONE;
            end else begin
              w_tmr_nxt[i] = r_tmr[i] + C_ONE;
            end
          end
          M_BLING: begin
            if (led_bling[i]) begin
              if (r_tmr[i] >= C_BLING) begin
                w_led_nxt[i] = ~r_led[i];
                w_tmr_nxt[i] = C_ONE;
              end else begin
                w_tmr_nxt[i] = r_tmr[i] + C_ONE;
              end
            end
          end
          M_BREATH: begin
            if (r_tmr[i] >= C_BREATH) begin
              w_tmr_nxt[i] = C_ONE;
              if (r_d[i] >= reg_breath) begin
                w_d_nxt[i] = '0;
                if (r_r[i] >= reg_breath) begin
                  w_r_nxt[i] = '0;
                  w_f_nxt[i] = ~r_f[i];
                end else begin
                  w_r_nxt[i] = r_r[i] + 8'd1;
                end
              end else begin
                w_d_nxt[i] = r_d[i] + 8'd1;
              end
            end else begin
              w_tmr_nxt[i] = r_tmr[i] + C_ONE;
            end
            w_led_nxt[i] = w_f_nxt[i] ? (w_d_nxt[i] < w_r_nxt[i])
                                      : (w_d_nxt[i] >= w_r_nxt[i]);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led      <= '0;
      r_f        <= '0;
      r_din_prev <= '0;
      r_req      <= 1'b0;
      for (int unsigned i = 0; i < NUM_LED; i++) begin
        r_tmr[i] <= '0;
        r_d[i]   <= '0;
        r_r[i]   <= '0;
      end
    end else begin
      r_led <= w_led_nxt;
      r_f   <= w_f_nxt;
      if (vld) r_din_prev <= reg_din;
      // Raised in the first cycle the new LED vector is visible.
      r_req <= vld | (w_led_nxt != r_led);
      for (int unsigned i = 0; i < NUM_LED; i++) begin
        r_tmr[i] <= w_tmr_nxt[i];
        r_d[i]   <= w_d_nxt[i];
        r_r[i]   <= w_r_nxt[i];
      end
    end
  end

  // Shifter: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_frame <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_load) r_frame <= r_led;
      r_pend  <= (w_load || r_state == IDLE) ? 1'b0 : (r_pend | r_req);
    end
  end

  // Shifter: next state
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_req) begin
          w_state_nxt = DATA_LO;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      DATA_LO: w_state_nxt = DATA_HI;
      DATA_HI: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = LATCH;
        end else begin
          w_state_nxt = DATA_LO;
          w_idx_nxt   = r_idx + 1'b1;
        end
      end
      LATCH: begin
        if (r_req || r_pend) begin
          w_state_nxt = DATA_LO;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shifter: outputs
  always_comb begin
    w_shifted = r_frame >> r_idx;
    sft_shcp  = (r_state == DATA_HI);
    sft_ds    = ((r_state == DATA_LO) || (r_state == DATA_HI)) ? w_shifted[0] : 1'b0;
    sft_stcp  = (r_state == LATCH);
    busy      = (r_state != IDLE);
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed testbench for led_pwm_ctrl (NUM_LED=8, short timer periods).
module tb_led_pwm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic [31:0] reg_din;
  logic [7:0]  reg_breath;
  logic [7:0]  led_bling;
  logic        sft_shcp, sft_ds, sft_stcp, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Frame capture
  int         frame_cnt = 0;
  logic [7:0] log_bits  [256];
  int         log_start [256];
  int         log_stcp  [256];
  int         log_busy  [256];
  logic [7:0] cur_bits;
  int         bitcnt, busy_run, cur_start;
  logic       prev_busy, prev_stcp;

  led_pwm_ctrl #(
    .NUM_LED(8), .CNT_W(8), .SPARK_MAX(10), .BLING_MAX(8), .BREATH_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .reg_din(reg_din),
    .reg_breath(reg_breath), .led_bling(led_bling),
    .sft_shcp(sft_shcp), .sft_ds(sft_ds), .sft_stcp(sft_stcp), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      bitcnt = 0; busy_run = 0; prev_busy = 1'b0; prev_stcp = 1'b0; cur_bits = '0;
    end else begin
      if (busy && (!prev_busy || prev_stcp)) begin
        cur_start = cyc; busy_run = 0; bitcnt = 0; cur_bits = '0;
      end
      if (busy) busy_run++;
      if (sft_shcp && bitcnt < 8) begin
        cur_bits[bitcnt] = sft_ds;
        bitcnt++;
      end
      if (sft_stcp && frame_cnt < 256) begin
        log_bits[frame_cnt]  = cur_bits;
        log_start[frame_cnt] = cur_start;
        log_stcp[frame_cnt]  = cyc;
        log_busy[frame_cnt]  = busy_run;
        frame_cnt++;
      end
      prev_busy = busy;
      prev_stcp = sft_stcp;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [31:0] din);
    reg_din = din;
    vld = 1'b1;
    tick();
    vld = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frame_cnt < n && k < budget) begin
      tick();
      k++;
    end
    check("frame_wait", (frame_cnt >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t0, hi;
    logic [15:0] pat;

    rst_n = 1'b0; vld = 1'b0; reg_din = '0; reg_breath = 8'd3; led_bling = '0;
    #2;
    check("reset_outs", {28'd0, sft_shcp, sft_ds, sft_stcp, busy}, 32'd0);
    check("reset_led", dut.r_led, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ON on ch0/ch1: single 17-cycle frame 1,1,0,...
    base = frame_cnt;
    strobe(32'h0000_0011);
    t0 = cyc;
    check("on_led", dut.r_led, 32'h03);
    wait_frames(base + 1, 60);
    check("frame_bits", log_bits[base], 32'h03);
    check("frame_start", log_start[base], t0 + 1);
    check("stcp_cycle", log_stcp[base] - log_start[base] + 1, 32'd17);
    check("busy_len", log_busy[base], 32'd17);
    repeat (30) tick();
    check("single_frame", frame_cnt, base + 1);

    // SPARK one-shot on ch0
    strobe(32'h0);
    repeat (60) tick();
    base = frame_cnt;
    strobe(32'h0000_0002);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (dut.r_led[0]) hi++;
      tick();
    end
    check("spark_high", hi, 32'd10);
    wait_frames(base + 2, 100);
    check("spark_frame1", log_bits[base], 32'h01);
    check("spark_frame2", log_bits[base + 1], 32'h00);
    check("spark_pending", log_start[base + 1], log_stcp[base] + 1);
    repeat (40) tick();
    check("spark_frames", frame_cnt, base + 2);
    check("spark_tmr", dut.r_tmr[0], 32'd0);

    // SPARK1 on ch3; repeated strobe keeps phase
    strobe(32'h0000_3000);
    check("sp1_start", dut.r_led[3], 32'd1);
    repeat (9) tick();
    check("sp1_hold", dut.r_led[3], 32'd1);
    tick();
    check("sp1_toggle", dut.r_led[3], 32'd0);
    repeat (3) tick();
    strobe(32'h0000_3000);
    check("sp1_same_code", dut.r_led[3], 32'd0);
    repeat (5) tick();
    check("sp1_phase_lo", dut.r_led[3], 32'd0);
    tick();
    check("sp1_phase_hi", dut.r_led[3], 32'd1);
    repeat (10) tick();
    check("sp1_low_again", dut.r_led[3], 32'd0);

    // New code (BLING on ch2 and ch3) restarts led=1
    strobe(32'h0000_4400);
    check("bling_start", {30'd0, dut.r_led[3:2]}, 32'h3);
    for (int p = 1; p <= 16; p++) begin
      led_bling = 8'h04;
      tick();
      led_bling = '0;
      if (p == 7)  check("bling_p7", dut.r_led[2], 32'd1);
      if (p == 8)  check("bling_p8", dut.r_led[2], 32'd0);
      if (p == 15) check("bling_p15", dut.r_led[2], 32'd0);
      if (p == 16) check("bling_p16", dut.r_led[2], 32'd1);
      repeat (3) tick();
    end
    check("bling_idle_led", dut.r_led[3], 32'd1);
    check("bling_idle_tmr", dut.r_tmr[3], 32'd1);

    // BREATH on ch5, reg_breath=3, step every 4 cycles
    strobe(32'h0050_0000);
    check("breath_entry", dut.r_led[5], 32'd1);
    pat = '0;
    for (int k = 0; k < 16; k++) begin
      repeat (4) tick();
      pat[k] = dut.r_led[5];
    end
    check("breath_pattern", pat, 32'h4677);
    check("breath_flip", dut.r_f[5], 32'd1);
    repeat (8) tick();
    check("breath_d", dut.r_d[5], 32'd2);
    strobe(32'h0010_0000);
    check("breath_on_led", dut.r_led[5], 32'd1);
    check("breath_clear", {dut.r_f[5], dut.r_d[5], dut.r_r[5]}, 32'd0);
    repeat (100) tick();

    // Requests during busy coalesce into one extra frame
    base = frame_cnt;
    strobe(32'h0000_0001);
    repeat (3) tick();
    strobe(32'h0000_0002);
    wait_frames(base + 2, 100);
    check("coal_frame1", log_bits[base], 32'h01);
    check("coal_frame2", log_bits[base + 1], 32'h00);
    check("coal_start", log_start[base + 1], log_stcp[base] + 1);
    repeat (60) tick();
    check("coal_count", frame_cnt, base + 2);

    // Timer at max and vld together: vld reloads
    strobe(32'h0000_0002);
    repeat (9) tick();
    check("spark_at_max", dut.r_tmr[0], 32'd10);
    strobe(32'h0000_0002);
    check("vld_win_led", dut.r_led[0], 32'd1);
    check("vld_win_tmr", dut.r_tmr[0], 32'd1);
    repeat (9) tick();
    check("vld_win_hold", dut.r_led[0], 32'd1);
    tick();
    check("vld_win_fall", dut.r_led[0], 32'd0);
    repeat (60) tick();

    // Reset mid-frame
    base = frame_cnt;
    strobe(32'h0000_0011);
    repeat (6) tick();
    check("pre_reset_busy", busy, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", {28'd0, sft_shcp, sft_ds, sft_stcp, busy}, 32'd0);
    check("async_reset_led", dut.r_led, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (50) tick();
    check("no_frame_after_reset", frame_cnt, base);
    check("idle_after_reset", busy, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_pwm_ctrl.md
LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Interface
REQ-001 Parameter NUM_LED, default 8: number of LED channels, range 1..16.
REQ-002 Parameter CNT_W, default 25: width of each channel timer.
REQ-003 Parameter SPARK_MAX, default 30000000: SPARK/SPARK1 period in clk cycles (300 ms at 100 MHz).
REQ-004 Parameter BLING_MAX, default 8: BLING period in led_bling ticks.
REQ-005 Parameter BREATH_MAX, default 24'h180000: BREATH step period in clk cycles.
REQ-006 clk  input  1: single clock; all state on rising edge.
REQ-007 rst_n  input  1: asynchronous, active-low reset.
REQ-008 vld  input  1: one-cycle strobe; samples reg_din.
REQ-009 reg_din  input  4*NUM_LED: mode code per channel; channel i = bits [4i+3:4i]; held stable between strobes.
REQ-010 reg_breath  input  8: BREATH ramp length; applies to all channels.
REQ-011 led_bling  input  NUM_LED: per-channel BLING advance tick.
REQ-012 sft_shcp  output  1: shift-register shift clock.
REQ-013 sft_ds  output  1: shift-register serial data.
REQ-014 sft_stcp  output  1: shift-register storage latch pulse.
REQ-015 busy  output  1: high while a frame is being shifted.

Function
REQ-016 Mode codes SHALL be: 0 OFF, 1 ON, 2 SPARK, 3 SPARK1, 4 BLING, 5 BREATH; codes 6..15 SHALL hold the current LED state with the timer stopped.
REQ-017 On vld, OFF/ON SHALL set led[i] to 0/1 the next cycle and clear the channel timer and breath state.
REQ-018 SPARK on vld: led[i]=1 and timer=1; the timer SHALL count each cycle; at SPARK_MAX led[i] SHALL toggle to 0 and the timer SHALL clear (one-shot).
REQ-019 SPARK1: on vld with a changed channel code, led[i]=1 and timer=1; on vld with an unchanged code, led[i] and timer SHALL be left untouched; at SPARK_MAX led[i] SHALL toggle and the timer SHALL reload to 1 (free-running blink).
REQ-020 BLING: same as SPARK1, except the timer SHALL advance only on cycles with led_bling[i]=1 and the period SHALL be BLING_MAX.
REQ-021 BREATH is legal on every channel: a timer of period BREATH_MAX produces a step; per step, duty counter d SHALL count 0..reg_breath and then wrap to 0; each wrap SHALL advance round counter r (0..reg_breath, then wrap to 0); each r wrap SHALL toggle direction flag f.
REQ-022 BREATH output: led[i] = (d >= r) when f=0, and (d < r) when f=1.
REQ-023 BREATH entry with a changed code SHALL restart the timer at 1; d, r and f SHALL be cleared only by OFF/ON or reset.
REQ-024 Changed-code detection SHALL compare reg_din against a registered copy of the previous reg_din.
REQ-025 Timer reaching max and vld in the same cycle: vld SHALL win.
REQ-026 A frame request SHALL be raised one cycle after vld, or on any cycle in which any led[i] changes.
REQ-027 Frame: for k = 0..NUM_LED-1, with bit led[k] shifted first, sft_ds SHALL be driven with sft_shcp=0 for one cycle, then sft_shcp=1 for one cycle; after the last bit, sft_stcp=1 for one cycle; a frame SHALL last 2*NUM_LED+1 cycles.
REQ-028 busy SHALL be high from the first ds cycle through the stcp cycle.
REQ-029 A request raised while busy SHALL set a single pending flag; the next frame SHALL start on the cycle after stcp and send the then-current led vector; multiple requests SHALL coalesce into one frame.
REQ-030 The shifter SHALL be an FSM with states IDLE, DATA_LO, DATA_HI and LATCH and a bit index of width clog2(NUM_LED)+1.
REQ-031 Timer arithmetic SHALL be CNT_W bits unsigned; SPARK_MAX and BREATH_MAX SHALL be < 2^CNT_W.

Reset
REQ-032 rst_n low SHALL asynchronously clear all led bits, timers, d, r, f, pending flag and FSM state (IDLE); sft_shcp, sft_ds, sft_stcp and busy SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no stcp pulse; no frame SHALL be sent after release until a request occurs.

Verification
REQ-034 NUM_LED=8, vld with reg_din=32'h0000_0011 -> frame shifts bits 1,1,0,0,0,0,0,0; stcp fires at cycle 17 of the frame; busy is high for 17 cycles.
REQ-035 SPARK_MAX=10, ch0 SPARK -> led[0] high for 10 cycles, then 0; two frames sent; the timer stays 0 afterwards.
REQ-036 SPARK1 on ch3, followed by a repeated vld with the same code -> blink phase is not reset; a new code restarts led[3]=1.
REQ-037 BLING_MAX=8, led_bling[2] pulsed every 4 cycles -> led[2] toggles every 32 cycles; with led_bling held 0 there is no toggle.
REQ-038 BREATH_MAX=4, reg_breath=3 on ch5 -> duty ramps 0/4..4/4 and f flips after 16 steps; ON then clears d, r and f.
REQ-039 LED change during busy plus a vld -> exactly one extra frame starts the cycle after stcp; rst_n asserted mid-frame -> all outputs 0 immediately.
